pc_redirect_ctrl: RTL and testbench

//  Next-fetch-PC controller for the dual-issue front end.

---
 rtl/pc_ctrl_pkg.sv | 8 +
 rtl/redirect_prio_mux.sv | 22 ++
 rtl/pc_redirect_ctrl.sv | 86 ++++++++
 tb/tb_pc_redirect_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared constants and enums for the next-fetch-PC controller.
package pc_ctrl_pkg;
    localparam int ADDR_W = 32;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;
    localparam int FETCH_BYTES = 8;
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
    typedef enum logic [1:0] {SRC_SEQ, SRC_PRED, SRC_MISPRED, SRC_EXCP} redirect_src_t;
endpackage

// File: rtl/redirect_prio_mux.sv
// redirect_prio_mux: picks the next fetch target and its source, excp > mispred > pending > pred > sequential.
module redirect_prio_mux import pc_ctrl_pkg::*; #(
    parameter int ADDR_W = pc_ctrl_pkg::ADDR_W
) (
    input  logic              excp_valid,
    input  logic [ADDR_W-1:0] excp_target,
    input  logic              mispred_valid,
    input  logic [ADDR_W-1:0] mispred_target,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] pend_target,
    input  redirect_src_t     pend_src,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_target,
    input  logic [ADDR_W-1:0] seq_target,
    output logic [ADDR_W-1:0] target,
    output redirect_src_t     src
);
    assign target = excp_valid ? excp_target : mispred_valid ? mispred_target :
                    pend_valid ? pend_target : pred_valid ? pred_target : seq_target;
    assign src = excp_valid ? SRC_EXCP : mispred_valid ? SRC_MISPRED :
                 pend_valid ? pend_src : pred_valid ? SRC_PRED : SRC_SEQ;
endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: next-fetch-PC controller with pause-time redirect buffering and IF flush.
module pc_redirect_ctrl import pc_ctrl_pkg::*; #(
    parameter int                ADDR_W      = pc_ctrl_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = pc_ctrl_pkg::RESET_PC,
    parameter int                FETCH_BYTES = pc_ctrl_pkg::FETCH_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        pause,
    input  logic              excp_valid_i,
    input  logic [ADDR_W-1:0] excp_target_i,
    input  logic              br_mispred_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              pred_valid_i,
    input  logic [ADDR_W-1:0] pred_target_i,
    output logic [ADDR_W-1:0] pc_1_o,
    output logic [ADDR_W-1:0] pc_2_o,
    output logic              inst_en_o_1,
    output logic              inst_en_o_2,
    output logic              flush_o,
    output logic [1:0]        redirect_src_o
);
    localparam int OFF_W = $clog2(FETCH_BYTES);
    localparam int SEQ_W = ADDR_W - OFF_W;
    state_t state, state_nxt;
    redirect_src_t src_q, pend_src, mux_src, cap_src;
    logic pend_valid, advance, capture, redirect, unused_pause;
    logic [ADDR_W-1:0] pend_target, mux_target, seq_pc, cap_target;
    assign redirect = excp_valid_i | br_mispred_i;
    assign unused_pause = ^pause[5:1];
    assign seq_pc = {pc_1_o[ADDR_W-1:OFF_W] + SEQ_W'(1), OFF_W'(0)};
    redirect_prio_mux #(.ADDR_W(ADDR_W)) u_mux (
        .excp_valid     (excp_valid_i),
        .excp_target    (excp_target_i),
        .mispred_valid  (br_mispred_i),
        .mispred_target (br_target_i),
        .pend_valid     (pend_valid),
        .pend_target    (pend_target),
        .pend_src       (pend_src),
        .pred_valid     (pred_valid_i),
        .pred_target    (pred_target_i),
        .seq_target     (seq_pc),
        .target         (mux_target),
        .src            (mux_src)
    );
    always_ff @(posedge clk)
        state <= rst ? BOOT : state_nxt;
    always_comb
        state_nxt = (state == BOOT) ? RUN :
                    (pause[0] && (state == HOLD || redirect)) ? HOLD : RUN;
    // A pending excp is never displaced by a later mispred; it is older in program order.
    always_comb begin
        advance = (state != BOOT) && !pause[0];
        capture = (state != BOOT) && pause[0] &&
                  (excp_valid_i || (br_mispred_i && !(pend_valid && pend_src == SRC_EXCP)));
        cap_target = excp_valid_i ? excp_target_i : br_target_i;
        cap_src = excp_valid_i ? SRC_EXCP : SRC_MISPRED;
    end
    always_ff @(posedge clk) begin
        if (rst || advance) begin
            pend_valid <= 1'b0;
            pend_target <= '0;
            pend_src <= SRC_SEQ;
        end else if (capture) begin
            pend_valid <= 1'b1;
            pend_target <= cap_target;
            pend_src <= cap_src;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_1_o <= RESET_PC;
            inst_en_o_1 <= 1'b0;
            flush_o <= 1'b0;
            src_q <= SRC_SEQ;
        end else begin
            if (advance) pc_1_o <= mux_target;
            inst_en_o_1 <= advance;
            flush_o <= redirect;
            src_q <= advance ? mux_src : SRC_SEQ;
        end
    end
    assign pc_2_o = pc_1_o + ADDR_W'(4);
    assign inst_en_o_2 = inst_en_o_1 & ~pc_1_o[2];
    assign redirect_src_o = src_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed-vector bench for pc_redirect_ctrl.
module tb_pc_redirect_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] pause = '0;
    logic excp_valid_i = 1'b0, br_mispred_i = 1'b0, pred_valid_i = 1'b0;
    logic [31:0] excp_target_i = '0, br_target_i = '0, pred_target_i = '0;
    logic [31:0] pc_1_o, pc_2_o;
    logic inst_en_o_1, inst_en_o_2, flush_o;
    logic [1:0] redirect_src_o;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    pc_redirect_ctrl dut (
        .clk(clk), .rst(rst), .pause(pause),
        .excp_valid_i(excp_valid_i), .excp_target_i(excp_target_i),
        .br_mispred_i(br_mispred_i), .br_target_i(br_target_i),
        .pred_valid_i(pred_valid_i), .pred_target_i(pred_target_i),
        .pc_1_o(pc_1_o), .pc_2_o(pc_2_o),
        .inst_en_o_1(inst_en_o_1), .inst_en_o_2(inst_en_o_2),
        .flush_o(flush_o), .redirect_src_o(redirect_src_o)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_state(input string tag, input logic [31:0] pc, input logic en1,
                             input logic en2, input logic fl, input logic [1:0] src);
        chk({tag, ".pc1"}, pc_1_o, pc);
        chk({tag, ".pc2"}, pc_2_o, pc + 32'd4);
        chk({tag, ".en1"}, 32'(inst_en_o_1), 32'(en1));
        chk({tag, ".en2"}, 32'(inst_en_o_2), 32'(en2));
        chk({tag, ".flush"}, 32'(flush_o), 32'(fl));
        chk({tag, ".src"}, 32'(redirect_src_o), 32'(src));
    endtask
    initial begin
        step(); step();
        chk_state("reset", 32'h1c000000, 0, 0, 0, 2'b00);
        rst = 1'b0;
        step();
        chk_state("boot", 32'h1c000000, 0, 0, 0, 2'b00);
        step();
        chk_state("run1", 32'h1c000008, 1, 1, 0, 2'b00);
        step();
        chk_state("run2", 32'h1c000010, 1, 1, 0, 2'b00);
        pause = 6'b000001;
        step();
        chk_state("pause1", 32'h1c000010, 0, 0, 0, 2'b00);
        step();
        chk_state("pause2", 32'h1c000010, 0, 0, 0, 2'b00);
        pause = '0;
        step();
        chk_state("release", 32'h1c000018, 1, 1, 0, 2'b00);
        br_mispred_i = 1'b1; br_target_i = 32'h1c000104;
        pred_valid_i = 1'b1; pred_target_i = 32'h1c000200;
        step();
        chk_state("prio", 32'h1c000104, 1, 0, 1, 2'b10);
        br_mispred_i = 1'b0; pred_valid_i = 1'b0;
        step();
        chk_state("prio_seq", 32'h1c000108, 1, 1, 0, 2'b00);
        pred_valid_i = 1'b1;
        step();
        chk_state("pred", 32'h1c000200, 1, 1, 0, 2'b01);
        pred_valid_i = 1'b0;
        pause = 6'b000001;
        excp_valid_i = 1'b1; excp_target_i = 32'h1c001000;
        step();
        chk_state("pend_excp", 32'h1c000200, 0, 0, 1, 2'b00);
        excp_valid_i = 1'b0;
        br_mispred_i = 1'b1; br_target_i = 32'h1c000300;
        step();
        chk_state("pend_mis", 32'h1c000200, 0, 0, 1, 2'b00);
        br_mispred_i = 1'b0;
        step();
        chk_state("pend_idle", 32'h1c000200, 0, 0, 0, 2'b00);
        pause = '0;
        step();
        chk_state("pend_rel", 32'h1c001000, 1, 1, 0, 2'b11);
        step();
        chk_state("pend_seq", 32'h1c001008, 1, 1, 0, 2'b00);
        excp_valid_i = 1'b1; excp_target_i = 32'hfffffff8;
        step();
        chk_state("wrap_excp", 32'hfffffff8, 1, 1, 1, 2'b11);
        excp_valid_i = 1'b0;
        step();
        chk_state("wrap", 32'h00000000, 1, 1, 0, 2'b00);
        pause = 6'b000001;
        br_mispred_i = 1'b1; br_target_i = 32'h1c000300;
        step();
        chk_state("hold_cap", 32'h00000000, 0, 0, 1, 2'b00);
        br_mispred_i = 1'b0;
        rst = 1'b1;
        step();
        chk_state("hold_rst", 32'h1c000000, 0, 0, 0, 2'b00);
        rst = 1'b0; pause = '0;
        step();
        chk_state("rst_boot", 32'h1c000000, 0, 0, 0, 2'b00);
        step();
        chk_state("rst_run", 32'h1c000008, 1, 1, 0, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
